// File: rtl/regs_wb_sched_if.sv
// Writeback scheduler bus: two writeback requesters, decode reservation and
// hazard query, and the registered write port toward the register file.
interface regs_wb_sched_if #(
  parameter int X_LEN = 32
);
  logic             req0_valid;
  logic [4:0]       req0_addr;
  logic [X_LEN-1:0] req0_data;
  logic             req0_ready;

  logic             req1_valid;
  logic [4:0]       req1_addr;
  logic [X_LEN-1:0] req1_data;
  logic             req1_ready;

  logic             iss_valid;
  logic [4:0]       iss_addr;
  logic             iss_ready;

  logic [4:0]       rd_addr_a;
  logic [4:0]       rd_addr_b;
  logic             hazard_a;
  logic             hazard_b;

  logic [4:0]       W_Addr;
  logic [X_LEN-1:0] W_Data;
  logic             Reg_Write;
  logic             err_underflow;

  // Requester / decode side
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output iss_valid, iss_addr,
    input  iss_ready,
    output rd_addr_a, rd_addr_b,
    input  hazard_a, hazard_b,
    input  W_Addr, W_Data, Reg_Write, err_underflow
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  iss_valid, iss_addr,
    output iss_ready,
    input  rd_addr_a, rd_addr_b,
    output hazard_a, hazard_b,
    output W_Addr, W_Data, Reg_Write, err_underflow
  );
endinterface

// File: rtl/regs_wb_sched.sv
// Writeback scheduler and RAW hazard scoreboard for the 32-entry register
// file. Two requesters share the single write port under round-robin; each
// register 1..31 carries a saturating count of reserved-but-uncommitted writes.
module regs_wb_sched #(
  parameter int X_LEN = 32,
  parameter int CNT_W = 2
) (
  input  logic           clk_Regs,
  input  logic           rst,
  regs_wb_sched_if.slave io_bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // r_rr: 0 -> requester 0 wins a tie, 1 -> requester 1 wins a tie
  logic                   r_rr;
  logic                   r_reg_write;
  logic [4:0]             r_w_addr;
  logic [X_LEN-1:0]       r_w_data;
  logic                   r_err;
  logic [CNT_W-1:0]       r_cnt [32];

  logic                   w_grant0;
  logic                   w_grant1;
  logic                   w_gnt_any;
  logic [4:0]             w_gnt_addr;
  logic [X_LEN-1:0]       w_gnt_data;
  logic                   w_iss_ready;
  logic                   w_iss_fire;
  logic [31:0]            w_inc_vec;
  logic [31:0]            w_dec_vec;

  // Round-robin arbitration between the two writeback requesters
  always_comb begin
    w_grant0   = 1'b0;
    w_grant1   = 1'b0;
    w_gnt_addr = io_bus.req0_addr;
    w_gnt_data = io_bus.req0_data;
    if (io_bus.req0_valid && io_bus.req1_valid) begin
      w_grant0 = ~r_rr;
      w_grant1 = r_rr;
    end else begin
      w_grant0 = io_bus.req0_valid;
      w_grant1 = io_bus.req1_valid;
    end
    if (w_grant1) begin
      w_gnt_addr = io_bus.req1_addr;
      w_gnt_data = io_bus.req1_data;
    end
  end

  assign w_gnt_any         = w_grant0 | w_grant1;
  assign io_bus.req0_ready = w_grant0;
  assign io_bus.req1_ready = w_grant1;

  // Reservation is refused only when the target counter is saturated
  assign w_iss_ready      = (io_bus.iss_addr == 5'd0) || (r_cnt[io_bus.iss_addr] != CNT_MAX);
  assign w_iss_fire       = io_bus.iss_valid && w_iss_ready && (io_bus.iss_addr != 5'd0);
  assign io_bus.iss_ready = w_iss_ready;

  // No bypass: a register stays hazardous through its commit cycle
  assign io_bus.hazard_a = (io_bus.rd_addr_a != 5'd0) && (r_cnt[io_bus.rd_addr_a] != '0);
  assign io_bus.hazard_b = (io_bus.rd_addr_b != 5'd0) && (r_cnt[io_bus.rd_addr_b] != '0);

  assign io_bus.W_Addr        = r_w_addr;
  assign io_bus.W_Data        = r_w_data;
  assign io_bus.Reg_Write     = r_reg_write;
  assign io_bus.err_underflow = r_err;

  // Per-register increment (reservation) and decrement (commit) strobes
  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    for (int i = 1; i < 32; i++) begin
      w_inc_vec[i] = w_iss_fire && (io_bus.iss_addr == 5'(i));
      w_dec_vec[i] = r_reg_write && (r_w_addr == 5'(i));
    end
  end

  // Round-robin pointer: after a grant, the other requester gets the next tie
  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst)
      r_rr <= 1'b0;
    else if (w_gnt_any)
      r_rr <= w_grant0;
  end

  // Write-port register stage; writes to r0 are accepted but never committed
  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst) begin
      r_reg_write <= 1'b0;
      r_w_addr    <= '0;
      r_w_data    <= '0;
    end else begin
      r_reg_write <= w_gnt_any && (w_gnt_addr != 5'd0);
      if (w_gnt_any && (w_gnt_addr != 5'd0)) begin
        r_w_addr <= w_gnt_addr;
        r_w_data <= w_gnt_data;
      end
    end
  end

  // Pending-write counters; simultaneous reserve and commit cancel out
  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        case ({w_inc_vec[i], w_dec_vec[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          2'b01:   if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Sticky flag: a commit arrived for a register with nothing outstanding
  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (r_reg_write && (r_cnt[r_w_addr] == '0))
      r_err <= 1'b1;
  end

endmodule

// File: tb/tb_regs_wb_sched.sv
// Bench for regs_wb_sched: directed writeback / reservation sequences, a
// per-cycle comparison against a behavioural model, and literal spot checks.
module tb_regs_wb_sched;

  logic clk_Regs = 1'b0;
  logic rst      = 1'b1;

  always #5 clk_Regs = ~clk_Regs;

  regs_wb_sched_if #(.X_LEN(32)) bus ();

  regs_wb_sched #(.X_LEN(32), .CNT_W(2)) dut (
    .clk_Regs (clk_Regs),
    .rst      (rst),
    .io_bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: pending counts as plain integers, write port as the
  // last accepted nonzero-address transaction.
  int          m_cnt [32];
  int          m_rr;
  bit          m_rw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;
  int          m_g;
  bit          m_inc;

  function automatic int pick(input bit v0, input bit v1, input int rr);
    if (v0 && v1) return rr;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk_Regs) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_rr = 0; m_rw = 0; m_addr = 0; m_data = 0; m_err = 0;
    end else begin
      m_inc = bus.iss_valid && (bus.iss_addr != 0) && (m_cnt[bus.iss_addr] < 3);
      if (m_rw && m_cnt[m_addr] == 0) m_err = 1;
      if (m_inc && !(m_rw && m_addr == bus.iss_addr)) m_cnt[bus.iss_addr]++;
      if (m_rw && !(m_inc && m_addr == bus.iss_addr) && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
      m_g = pick(bus.req0_valid, bus.req1_valid, m_rr);
      m_rw = 0;
      if (m_g >= 0) begin
        m_rr = 1 - m_g;
        if (m_g == 0 && bus.req0_addr != 0) begin
          m_rw = 1; m_addr = bus.req0_addr; m_data = bus.req0_data;
        end
        if (m_g == 1 && bus.req1_addr != 0) begin
          m_rw = 1; m_addr = bus.req1_addr; m_data = bus.req1_data;
        end
      end
    end
  end

  // Every cycle out of reset: compare DUT outputs with the model
  always @(negedge clk_Regs) begin
    if (!rst) begin
      int g;
      g = pick(bus.req0_valid, bus.req1_valid, m_rr);
      chk("m_req0_ready", bus.req0_ready, (g == 0));
      chk("m_req1_ready", bus.req1_ready, (g == 1));
      chk("m_iss_ready", bus.iss_ready, (bus.iss_addr == 0) || (m_cnt[bus.iss_addr] < 3));
      chk("m_hazard_a", bus.hazard_a, (bus.rd_addr_a != 0) && (m_cnt[bus.rd_addr_a] != 0));
      chk("m_hazard_b", bus.hazard_b, (bus.rd_addr_b != 0) && (m_cnt[bus.rd_addr_b] != 0));
      chk("m_reg_write", bus.Reg_Write, m_rw);
      chk("m_err", bus.err_underflow, m_err);
      if (m_rw) begin
        chk("m_w_addr", bus.W_Addr, m_addr);
        chk("m_w_data", bus.W_Data, m_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_Regs);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_Regs);
  endtask

  logic [4:0] wa [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
  logic       g0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
    bus.iss_valid  = 0; bus.iss_addr  = 0;
    bus.rd_addr_a  = 0; bus.rd_addr_b = 0;
    tick(); tick();
    rst = 0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.rd_addr_a = 5'(i + 1);
      bus.rd_addr_b = 5'(31 - i);
      bus.iss_addr  = 5'(i * 6);
      smp();
      chk("rst_reg_write", bus.Reg_Write, 0);
      chk("rst_w_addr", bus.W_Addr, 0);
      chk("rst_w_data", bus.W_Data, 0);
      chk("rst_hazard_a", bus.hazard_a, 0);
      chk("rst_hazard_b", bus.hazard_b, 0);
      chk("rst_iss_ready", bus.iss_ready, 1);
      chk("rst_err", bus.err_underflow, 0);
    end

    // Reserve r5 twice, then commit it via req0 and req1
    tick(); bus.rd_addr_a = 5; bus.rd_addr_b = 0; bus.iss_valid = 1; bus.iss_addr = 5;
    tick();
    tick(); bus.iss_valid = 0;
    bus.req0_valid = 1; bus.req0_addr = 5; bus.req0_data = 32'h12345678;
    smp();
    chk("r5_hazard", bus.hazard_a, 1);
    chk("r5_req0_ready", bus.req0_ready, 1);
    tick(); bus.req0_valid = 0;
    smp();
    chk("r5_reg_write", bus.Reg_Write, 1);
    chk("r5_w_addr", bus.W_Addr, 5);
    chk("r5_w_data", bus.W_Data, 32'h12345678);
    tick(); smp();
    chk("r5_reg_write_off", bus.Reg_Write, 0);
    chk("r5_w_addr_hold", bus.W_Addr, 5);
    chk("r5_hazard_one_left", bus.hazard_a, 1);
    tick(); bus.req1_valid = 1; bus.req1_addr = 5; bus.req1_data = 32'hCAFEF00D;
    smp();
    chk("r5_req1_ready", bus.req1_ready, 1);
    tick(); bus.req1_valid = 0;
    smp();
    chk("r5_w_data_req1", bus.W_Data, 32'hCAFEF00D);
    tick(); smp();
    chk("r5_hazard_clear", bus.hazard_a, 0);

    // Reserve r3 x2, r4 x2, then both requesters contend for 4 cycles
    for (int k = 0; k < 4; k++) begin
      tick(); bus.iss_valid = 1; bus.iss_addr = (k < 2) ? 5'd3 : 5'd4;
    end
    tick(); bus.iss_valid = 0;
    bus.rd_addr_a = 3; bus.rd_addr_b = 4;
    bus.req0_valid = 1; bus.req0_addr = 3; bus.req0_data = 32'hA3;
    bus.req1_valid = 1; bus.req1_addr = 4; bus.req1_data = 32'hB4;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      smp();
      chk("rr_req0_ready", bus.req0_ready, g0[i]);
      chk("rr_req1_ready", bus.req1_ready, !g0[i]);
      if (i > 0) chk("rr_w_addr", bus.W_Addr, wa[i-1]);
    end
    tick(); bus.req0_valid = 0; bus.req1_valid = 0;
    smp();
    chk("rr_w_addr_last", bus.W_Addr, 4);
    chk("rr_reg_write_last", bus.Reg_Write, 1);
    tick(); smp();
    chk("rr_hazard_a", bus.hazard_a, 0);
    chk("rr_hazard_b", bus.hazard_b, 0);

    // Saturate r7, then drain it
    bus.rd_addr_a = 7; bus.rd_addr_b = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); bus.iss_valid = 1; bus.iss_addr = 7;
      smp();
      chk("r7_iss_ready", bus.iss_ready, 1);
    end
    tick(); smp();
    chk("r7_iss_full", bus.iss_ready, 0);
    chk("r7_hazard", bus.hazard_a, 1);
    tick(); bus.iss_valid = 0;
    bus.req1_valid = 1; bus.req1_addr = 7; bus.req1_data = 32'h77;
    smp();
    chk("r7_req1_ready", bus.req1_ready, 1);
    tick(); bus.req1_valid = 0;
    smp();
    chk("r7_commit_still_full", bus.iss_ready, 0);
    tick(); smp();
    chk("r7_iss_ready_again", bus.iss_ready, 1);
    tick(); bus.req0_valid = 1; bus.req0_addr = 7; bus.req0_data = 32'h700;
    smp();
    tick(); bus.req0_data = 32'h701;
    smp();
    chk("r7_commit2", bus.Reg_Write, 1);
    tick(); bus.req0_valid = 0;
    smp();
    chk("r7_commit3_data", bus.W_Data, 32'h701);
    chk("r7_hazard_in_commit", bus.hazard_a, 1);
    tick(); smp();
    chk("r7_hazard_cleared", bus.hazard_a, 0);

    // Commit to r9 with nothing reserved
    tick(); bus.rd_addr_a = 9; bus.req0_valid = 1; bus.req0_addr = 9; bus.req0_data = 32'h9;
    smp();
    chk("uf_err_before", bus.err_underflow, 0);
    tick(); bus.req0_valid = 0;
    smp();
    chk("uf_reg_write", bus.Reg_Write, 1);
    chk("uf_err_commit_cycle", bus.err_underflow, 0);
    tick(); smp();
    chk("uf_err_set", bus.err_underflow, 1);
    tick(); smp();
    chk("uf_err_sticky", bus.err_underflow, 1);

    // Write to r0: accepted, never committed
    tick(); bus.req1_valid = 1; bus.req1_addr = 0; bus.req1_data = 32'hFFFFFFFF;
    smp();
    chk("r0_req1_ready", bus.req1_ready, 1);
    tick(); bus.req1_valid = 0;
    smp();
    chk("r0_no_write", bus.Reg_Write, 0);
    tick(); smp();
    chk("r0_no_write2", bus.Reg_Write, 0);

    // Reset with a write to r6 in flight
    tick(); bus.iss_valid = 1; bus.iss_addr = 6; bus.rd_addr_a = 6;
    tick(); bus.iss_valid = 0;
    bus.req0_valid = 1; bus.req0_addr = 6; bus.req0_data = 32'h66;
    smp();
    chk("r6_hazard", bus.hazard_a, 1);
    chk("r6_req0_ready", bus.req0_ready, 1);
    tick(); rst = 1; bus.req0_valid = 0;
    tick(); tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("r6_no_write", bus.Reg_Write, 0);
      chk("r6_hazard_reset", bus.hazard_a, 0);
      chk("r6_iss_ready", bus.iss_ready, 1);
      chk("r6_err_reset", bus.err_underflow, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
- Writeback scheduler and hazard scoreboard for the 32-entry register file.
- Arbitrates two writeback requesters (req0 = ALU, req1 = memory/load) onto the file's single write port with round-robin priority.
- Drives W_Addr / W_Data / Reg_Write from registers.
- Tracks outstanding producers per register so decode can stall on read-after-write hazards.

Parameters:
- X_LEN, 32, data width of register file words.
- CNT_W, 2, width of per-register pending-write counter; max outstanding = 2^CNT_W-1.

Ports:
- rst  input  1  asynchronous, active-high reset.
- clk_Regs  input  1  clock, shared with register file; all state updates on rising edge.
- req0_valid  input  1  requester 0 has a write.
- req0_addr  input  5  requester 0 destination.
- req0_data  input  X_LEN  requester 0 data.
- req0_ready  output  1  requester 0 accepted this cycle (combinational).
- req1_valid, req1_addr, req1_data, req1_ready  same as req0 for requester 1.
- iss_valid  input  1  decode reserves a destination register.
- iss_addr  input  5  register being reserved.
- iss_ready  output  1  reservation can be accepted (combinational).
- rd_addr_a  input  5  decode source A.
- rd_addr_b  input  5  decode source B.
- hazard_a  output  1  source A has pending write.
- hazard_b  output  1  source B has pending write.
- W_Addr  output  5  register-file write address (registered).
- W_Data  output  X_LEN  register-file write data (registered).
- Reg_Write  output  1  register-file write enable (registered).
- err_underflow  output  1  sticky: commit to register with zero pending count.

Behaviour:
- Reset (async, rst high): Reg_Write=0, W_Addr=0, W_Data=0, err_underflow=0, all pending counters=0, rr pointer=req0. Any accepted-but-uncommitted write is discarded. Reset mid-operation drops the in-flight write; no Reg_Write pulse after release until a new acceptance.
- Arbitration (combinational):
  - Only req0 valid -> grant 0.
  - Only req1 valid -> grant 1.
  - Both valid -> grant the side the rr pointer selects.
  - reqN_ready = grant to N. No backpressure from the register file; one grant every cycle possible.
- Pointer: on any grant, the pointer moves to the non-granted requester. With no grant, the pointer holds.
- Commit latency: a request accepted at edge N drives Reg_Write=1, W_Addr, W_Data during cycle N+1. The register file writes at edge N+1. With no grant, Reg_Write=0 next cycle; W_Addr/W_Data hold their previous values.
- Address 0: accepted (ready=1) but discarded. Reg_Write stays 0, no counter change.
- Scoreboard: one CNT_W-bit counter per register 1..31; register 0 is never tracked.
  - Increment at edge when iss_valid && iss_ready && iss_addr!=0.
  - Decrement at edge of commit (the edge where Reg_Write=1) for W_Addr.
  - Increment and decrement of the same register in the same cycle -> unchanged.
  - Decrement with count 0 -> stays 0, err_underflow set until reset.
- iss_ready = 0 only when iss_addr!=0 and its counter is at max (3 for CNT_W=2); otherwise 1. iss_addr=0 always ready, no effect.
- hazard_x = (rd_addr_x!=0) && counter[rd_addr_x]!=0, combinational.
  - During the commit cycle the counter is still nonzero, so hazard stays 1; it clears the cycle after commit. There is no bypass.

Test Plan:
- Reset then idle 5 cycles -> Reg_Write=0, W_Addr=0, W_Data=0, hazard_a/b=0, all iss_ready=1, err_underflow=0.
- req0 valid, addr 5, data 0x12345678, single cycle -> req0_ready=1 same cycle; next cycle Reg_Write=1, W_Addr=5, W_Data=0x12345678; following cycle Reg_Write=0.
- req0 and req1 both valid for 4 cycles (addrs 3 and 4) -> grants alternate 0,1,0,1; W_Addr sequence 3,4,3,4.
- iss addr 7 three times, no commits -> hazard_a=1 for rd_addr_a=7; 4th iss_ready=0. One commit to 7 -> iss_ready=1. All three commits -> hazard_a=0 the cycle after the last commit.
- Commit to addr 9 with count 0 -> err_underflow=1 and stays 1. A write to addr 0 -> ready=1, Reg_Write never asserts.
- Accept write to addr 6, assert rst before next edge -> Reg_Write stays 0 after rst release; counters 0.
